// File: rtl/ghostbus_pkg.sv
// Shared definitions for the ghostbus register bank: address map anchors,
// read-latency limit and the address-decode result type.
package ghostbus_pkg;

  localparam int unsigned CTRL_BASE = 'h00;
  localparam int unsigned STAT_BASE = 'h20;
  localparam int unsigned RLAT_MAX  = 4;

  typedef enum logic [1:0] {
    HIT_CTRL,
    HIT_STAT,
    HIT_RAM,
    HIT_NONE
  } hit_e;

endpackage

// File: rtl/ghostbus_rd_pipe.sv
// Read-return pipeline: RLAT stages of {valid, data}, stage 0 loaded from the
// read mux, flushed by reset. Data is held at zero whenever valid is low.
module ghostbus_rd_pipe
  import ghostbus_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned RLAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Out-of-range latencies are clamped into 1..RLAT_MAX.
  localparam int unsigned NST = (RLAT > RLAT_MAX) ? RLAT_MAX : ((RLAT < 1) ? 1 : RLAT);

  logic [NST-1:0]         vld_q, vld_d;
  logic [NST-1:0][DW-1:0] dat_q, dat_d;

  // Shift every stage forward one position per cycle.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int unsigned i = 1; i < NST; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Stage registers; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[NST-1];
  assign out_data  = dat_q[NST-1];

endmodule

// File: rtl/ghostbus_regbank.sv
// ghostbus_regbank: NCH control registers with write/read strobes, NCH status
// channels and one RAM, read back through an RLAT-cycle valid pipeline.
// Optional GHOSTBUS_REGBANK_RDCLR_EN: sticky status bits cleared on read.
module ghostbus_regbank #(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 32,
  parameter int unsigned GW       = 8,
  parameter int unsigned NCH      = 4,
  parameter int unsigned RD       = 8,
  parameter int unsigned RAM_W    = 4,
  parameter int unsigned RAM_BASE = 'h40,
  parameter int unsigned RLAT     = 1,
  parameter int unsigned INIT     = 'h42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     bus_addr,
  input  logic [DW-1:0]     bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [DW-1:0]     bus_rdata,
  output logic              bus_rvalid,
  output logic [NCH*GW-1:0] ctrl_out,
  output logic [NCH-1:0]    ctrl_wstb,
  output logic [NCH-1:0]    ctrl_rstb,
  input  logic [NCH*GW-1:0] status_in
);

  import ghostbus_pkg::*;

  localparam int unsigned   IW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned   RAW     = $clog2(RD);
  localparam logic [GW-1:0] INIT_GW = GW'(INIT);

  logic [NCH-1:0][GW-1:0] ctrl_q, ctrl_d;
  logic [NCH-1:0][GW-1:0] stat_q, stat_d;
  logic [NCH-1:0][GW-1:0] stat_live;
  logic [NCH-1:0]         wstb_q, wstb_d;
  logic [NCH-1:0]         rstb_q, rstb_d;
  logic [RAM_W-1:0]       ram_q [RD];

  logic [AW-1:0]  coff, soff, roff;
  hit_e           hit;
  logic [IW-1:0]  idx;
  logic [RAW-1:0] ridx;
  logic [DW-1:0]  rd_mux;
  logic           ram_we;
  logic           unused_wdata;

  assign stat_live    = status_in;
  assign unused_wdata = ^bus_wdata;

  // Decode the bus address into a region and a channel / word index.
  always_comb begin
    coff = bus_addr - AW'(CTRL_BASE);
    soff = bus_addr - AW'(STAT_BASE);
    roff = bus_addr - AW'(RAM_BASE);
    hit  = HIT_NONE;
    idx  = '0;
    ridx = roff[RAW-1:0];
    if (coff < AW'(NCH)) begin
      hit = HIT_CTRL;
      idx = coff[IW-1:0];
    end else if (soff < AW'(NCH)) begin
      hit = HIT_STAT;
      idx = soff[IW-1:0];
    end else if (roff < AW'(RD)) begin
      hit = HIT_RAM;
    end
  end

  // Read mux sees pre-write state, so a same-cycle write never leaks into the read.
  always_comb begin
    rd_mux = '0;
    case (hit)
      HIT_CTRL: rd_mux[GW-1:0]    = ctrl_q[idx];
      HIT_STAT: rd_mux[GW-1:0]    = stat_q[idx];
      HIT_RAM:  rd_mux[RAM_W-1:0] = ram_q[ridx];
      default:  rd_mux            = '0;
    endcase
  end

  // Next-state for control registers, strobes and status.
  always_comb begin
    ctrl_d = ctrl_q;
    wstb_d = '0;
    rstb_d = '0;
    if (bus_we && hit == HIT_CTRL) begin
      ctrl_d[idx] = bus_wdata[GW-1:0];
      wstb_d[idx] = 1'b1;
    end
    if (bus_re && hit == HIT_CTRL) begin
      rstb_d[idx] = 1'b1;
    end
`ifdef GHOSTBUS_REGBANK_RDCLR_EN
    // Clear the read channel, then OR in new events so a same-cycle set survives.
    stat_d = stat_q;
    if (bus_re && hit == HIT_STAT) begin
      stat_d[idx] = '0;
    end
    stat_d = stat_d | stat_live;
`else
    stat_d = stat_live;
`endif
    ram_we = rst_n && bus_we && (hit == HIT_RAM);
  end

  // Register state; reset restores INIT and clears strobes and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= {NCH{INIT_GW}};
      wstb_q <= '0;
      rstb_q <= '0;
      stat_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      wstb_q <= wstb_d;
      rstb_q <= rstb_d;
      stat_q <= stat_d;
    end
  end

  // RAM array, not reset; write port only.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ridx] <= bus_wdata[RAM_W-1:0];
    end
  end

  ghostbus_rd_pipe #(
    .DW   (DW),
    .RLAT (RLAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus_re),
    .in_data   (rd_mux),
    .out_valid (bus_rvalid),
    .out_data  (bus_rdata)
  );

  assign ctrl_out  = ctrl_q;
  assign ctrl_wstb = wstb_q;
  assign ctrl_rstb = rstb_q;

endmodule

// File: tb/tb_ghostbus_regbank.sv
// Directed self-checking bench for ghostbus_regbank (RLAT=3, NCH=4, GW=8).
module tb_ghostbus_regbank;

  localparam int unsigned AW       = 24;
  localparam int unsigned DW       = 32;
  localparam int unsigned GW       = 8;
  localparam int unsigned NCH      = 4;
  localparam int unsigned RD       = 8;
  localparam int unsigned RAM_W    = 4;
  localparam int unsigned RAM_BASE = 'h40;
  localparam int unsigned RLAT     = 3;
  localparam int unsigned INIT     = 'h42;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     bus_addr;
  logic [DW-1:0]     bus_wdata;
  logic              bus_we;
  logic              bus_re;
  logic [DW-1:0]     bus_rdata;
  logic              bus_rvalid;
  logic [NCH*GW-1:0] ctrl_out;
  logic [NCH-1:0]    ctrl_wstb;
  logic [NCH-1:0]    ctrl_rstb;
  logic [NCH*GW-1:0] status_in;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  ghostbus_regbank #(
    .AW       (AW),
    .DW       (DW),
    .GW       (GW),
    .NCH      (NCH),
    .RD       (RD),
    .RAM_W    (RAM_W),
    .RAM_BASE (RAM_BASE),
    .RLAT     (RLAT),
    .INIT     (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .ctrl_out   (ctrl_out),
    .ctrl_wstb  (ctrl_wstb),
    .ctrl_rstb  (ctrl_rstb),
    .status_in  (status_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read, return latency in cycles, data, and strobes seen one cycle later.
  task automatic do_read(input logic [AW-1:0] addr, output int lat,
                         output logic [DW-1:0] data, output logic [NCH-1:0] rstb1,
                         output logic [NCH-1:0] wstb1);
    bus_addr = addr;
    bus_re   = 1'b1;
    tick();
    bus_re = 1'b0;
    rstb1  = ctrl_rstb;
    wstb1  = ctrl_wstb;
    lat    = 1;
    while (bus_rvalid !== 1'b1 && lat < int'(RLAT) + 4) begin
      tick();
      lat++;
    end
    data = bus_rdata;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    rst_n = 1'b0;
    tick();
    tick();
    chk_cnt++;
    if (ctrl_out !== 32'h42424242) $display("FAIL reset_ctrl got=%h exp=%h", ctrl_out, 32'h42424242);
    else pass_cnt++;
    chk_cnt++;
    if (bus_rvalid !== 1'b0 || bus_rdata !== 32'h0) $display("FAIL reset_rd got=%b/%h exp=0/0", bus_rvalid, bus_rdata);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_wstb !== 4'b0 || ctrl_rstb !== 4'b0) $display("FAIL reset_stb got=%b/%b exp=0000/0000", ctrl_wstb, ctrl_rstb);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    do_read('h02, lat, d, rs, ws);
    chk_cnt++;
    if (lat !== int'(RLAT)) $display("FAIL reset_read_lat got=%0d exp=%0d", lat, RLAT);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 32'h00000042) $display("FAIL reset_read_data got=%h exp=%h", d, 32'h42);
    else pass_cnt++;
  endtask

  task automatic test_ctrl_write();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    do_write('h01, 32'hFFFF_FF5A);
    chk_cnt++;
    if (ctrl_out !== 32'h42425A42) $display("FAIL wr_ctrl got=%h exp=%h", ctrl_out, 32'h42425A42);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_wstb !== 4'b0010) $display("FAIL wr_wstb got=%b exp=0010", ctrl_wstb);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ctrl_wstb !== 4'b0000) $display("FAIL wr_wstb_drop got=%b exp=0000", ctrl_wstb);
    else pass_cnt++;
    do_read('h01, lat, d, rs, ws);
    chk_cnt++;
    if (rs !== 4'b0010) $display("FAIL rd_rstb got=%b exp=0010", rs);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 32'h5A || lat !== int'(RLAT)) $display("FAIL rd_ctrl got=%h@%0d exp=%h@%0d", d, lat, 32'h5A, RLAT);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_rstb !== 4'b0000) $display("FAIL rd_rstb_drop got=%b exp=0000", ctrl_rstb);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 4; i++) do_write(AW'(RAM_BASE + i), 32'hABCD_EF00 | DW'(i + 1));
    tick();
    for (int t = 1; t <= int'(RLAT) + 4; t++) begin
      bus_re   = (t <= 4);
      bus_addr = AW'(RAM_BASE + t - 1);
      tick();
      exp_v = (t >= int'(RLAT)) && (t < int'(RLAT) + 4);
      exp_d = exp_v ? DW'(t - int'(RLAT) + 1) : '0;
      chk_cnt++;
      if (bus_rvalid !== exp_v || bus_rdata !== exp_d)
        $display("FAIL b2b_t%0d got=%b/%h exp=%b/%h", t, bus_rvalid, bus_rdata, exp_v, exp_d);
      else pass_cnt++;
    end
    bus_re = 1'b0;
  endtask

  task automatic test_rw_same_cycle();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    bus_addr  = AW'(RAM_BASE + 1);
    bus_wdata = 32'h9;
    bus_we    = 1'b1;
    do_read(AW'(RAM_BASE + 1), lat, d, rs, ws);
    bus_we = 1'b0;
    chk_cnt++;
    if (d !== 32'h2 || lat !== int'(RLAT)) $display("FAIL rw_ram_old got=%h@%0d exp=2@%0d", d, lat, RLAT);
    else pass_cnt++;
    do_read(AW'(RAM_BASE + 1), lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h9) $display("FAIL rw_ram_new got=%h exp=9", d);
    else pass_cnt++;
    bus_wdata = 32'h77;
    bus_we    = 1'b1;
    do_read('h03, lat, d, rs, ws);
    bus_we = 1'b0;
    chk_cnt++;
    if (d !== 32'h42 || ws !== 4'b1000 || rs !== 4'b1000)
      $display("FAIL rw_ctrl got=%h w=%b r=%b exp=42 w=1000 r=1000", d, ws, rs);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_out !== 32'h77425A42) $display("FAIL rw_ctrl_val got=%h exp=%h", ctrl_out, 32'h77425A42);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    status_in = 32'h44332211;
    tick();
    do_read('h30, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h0 || lat !== int'(RLAT) || rs !== 4'b0)
      $display("FAIL unmap_rd got=%h@%0d r=%b exp=0@%0d r=0000", d, lat, rs, RLAT);
    else pass_cnt++;
    do_write('h20, 32'hFF);
    chk_cnt++;
    if (ctrl_wstb !== 4'b0 || ctrl_out !== 32'h77425A42)
      $display("FAIL stat_wr got=%b/%h exp=0000/%h", ctrl_wstb, ctrl_out, 32'h77425A42);
    else pass_cnt++;
    do_write('h04, 32'hEE);
    chk_cnt++;
    if (ctrl_wstb !== 4'b0 || ctrl_out !== 32'h77425A42)
      $display("FAIL unmap_wr got=%b/%h exp=0000/%h", ctrl_wstb, ctrl_out, 32'h77425A42);
    else pass_cnt++;
    do_read('h20, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h11 || rs !== 4'b0) $display("FAIL stat0_rd got=%h r=%b exp=11 r=0000", d, rs);
    else pass_cnt++;
    do_read('h23, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h44) $display("FAIL stat3_rd got=%h exp=44", d);
    else pass_cnt++;
    do_read('h24, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h0 || lat !== int'(RLAT)) $display("FAIL stat_oob got=%h@%0d exp=0@%0d", d, lat, RLAT);
    else pass_cnt++;
    do_read(AW'(RAM_BASE + RD), lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h0 || lat !== int'(RLAT)) $display("FAIL ram_oob got=%h@%0d exp=0@%0d", d, lat, RLAT);
    else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    bus_addr = 'h02;
    bus_re   = 1'b1;
    tick();
    bus_re = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    status_in = '0;
    for (int i = 0; i < int'(RLAT) + 3; i++) begin
      if (bus_rvalid !== 1'b0) seen++;
      tick();
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL flush_rvalid got=%0d exp=0", seen);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_out !== 32'h42424242) $display("FAIL flush_ctrl got=%h exp=%h", ctrl_out, 32'h42424242);
    else pass_cnt++;
    do_read('h20, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h0) $display("FAIL flush_stat got=%h exp=0", d);
    else pass_cnt++;
    do_read(AW'(RAM_BASE + 2), lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h3) $display("FAIL ram_keep got=%h exp=3", d);
    else pass_cnt++;
  endtask

`ifdef GHOSTBUS_REGBANK_RDCLR_EN
  task automatic test_rdclr();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    status_in = 32'h08;
    tick();
    status_in = '0;
    tick();
    do_read('h20, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h08 || rs !== 4'b0) $display("FAIL rdclr_first got=%h r=%b exp=08 r=0000", d, rs);
    else pass_cnt++;
    do_read('h20, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h00) $display("FAIL rdclr_second got=%h exp=00", d);
    else pass_cnt++;
    status_in = 32'h01;
    bus_addr  = 'h20;
    bus_re    = 1'b1;
    tick();
    bus_re    = 1'b0;
    status_in = '0;
    tick();
    tick();
    tick();
    do_read('h20, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'h01) $display("FAIL rdclr_setwins got=%h exp=01", d);
    else pass_cnt++;
  endtask
`else
  task automatic test_status_live();
    int lat;
    logic [DW-1:0] d;
    logic [NCH-1:0] rs, ws;
    status_in = 32'h00AB0000;
    tick();
    do_read('h22, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'hAB) $display("FAIL live_ab got=%h exp=ab", d);
    else pass_cnt++;
    status_in = 32'h00CD0000;
    tick();
    do_read('h22, lat, d, rs, ws);
    chk_cnt++;
    if (d !== 32'hCD) $display("FAIL live_cd got=%h exp=cd", d);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    status_in = '0;
    test_reset();
    test_ctrl_write();
    test_back_to_back();
    test_rw_same_cycle();
    test_unmapped();
    test_reset_flush();
`ifdef GHOSTBUS_REGBANK_RDCLR_EN
    test_rdclr();
`else
    test_status_live();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ghostbus_regbank.md
Name: ghostbus_regbank

Overview:
- Parametrised successor to the single-register ghostbus leaf.
- Provides NCH host-accessible control registers, each with its own write strobe and read strobe.
- Provides NCH read-only status channels and one host-accessible RAM at a configurable base address.
- Read data returns through a configurable-latency pipeline with a valid flag, so it sits on the ghostbus like any hand-decoded leaf module.

Parameters:
- AW, 24, bus address width.
- DW, 32, bus data width.
- GW, 8, control/status register width (GW <= DW).
- NCH, 4, number of control and status channels (1..16).
- RD, 8, RAM depth in words (power of two, 2..256).
- RAM_W, 4, RAM word width (RAM_W <= DW).
- RAM_BASE, 'h40, relative RAM base address; aligned to RD; must be >= 'h40.
- RLAT, 1, read latency in cycles (1..4).
- INIT, 'h42, reset value of every control register (truncated to GW).

Ports:
- clk  in  1  bus/system clock.
- rst_n  in  1  synchronous active-low reset.
- bus_addr  in  AW  relative address.
- bus_wdata  in  DW  write data.
- bus_we  in  1  write enable, single-cycle qualified.
- bus_re  in  1  read request, single-cycle qualified.
- bus_rdata  out  DW  read data, valid when bus_rvalid=1, else 0.
- bus_rvalid  out  1  read-data valid.
- ctrl_out  out  NCH*GW  control registers, channel k at [k*GW +: GW].
- ctrl_wstb  out  NCH  per-channel write strobe.
- ctrl_rstb  out  NCH  per-channel read strobe.
- status_in  in  NCH*GW  status inputs.

Behaviour:
- Address map:
  - ctrl k at 'h00+k.
  - status k at 'h20+k.
  - RAM at RAM_BASE..RAM_BASE+RD-1.
  - All other addresses are unmapped.
- Write (bus_we=1):
  - Control hit: ctrl_out[k] <= bus_wdata[GW-1:0] on the next edge; ctrl_wstb[k]=1 for exactly that one cycle, aligned with the new value.
  - RAM hit: word written from bus_wdata[RAM_W-1:0].
  - Writes to status or unmapped addresses are ignored with no strobe.
- Read (bus_re=1):
  - Address captured on the request cycle.
  - bus_rvalid and bus_rdata appear exactly RLAT cycles after the request.
  - Data is zero-extended to DW; unmapped reads return 0 and still assert rvalid.
  - Control hit: ctrl_rstb[k]=1 in the cycle after the request, independent of RLAT.
- Back-to-back reads every cycle are fully pipelined: one rvalid per request, in order.
- bus_we and bus_re in the same cycle:
  - Both are accepted.
  - Same address: the read returns the pre-write value. This holds for control and RAM, so the RAM is read-before-write.
- Status (without the optional feature): status_in is registered once every cycle; a read returns that registered value.
- Reset (rst_n=0 at an edge):
  - ctrl_out = INIT, all strobes 0, bus_rvalid 0, bus_rdata 0.
  - Read pipeline flushed: any in-flight read is dropped with no rvalid.
  - Status registers cleared.
  - RAM contents are not reset.
- Requests presented while rst_n=0 are ignored.
- No backpressure: the host never stalls the pipeline.

Optional Feature:
- Macro: GHOSTBUS_REGBANK_RDCLR_EN.
- Defined:
  - Each status register is sticky: stat[k] <= stat[k] | status_in[k] every cycle.
  - A read of status k returns the current sticky value and clears it on the following edge.
  - Bits asserted on status_in in that same clearing cycle survive (set wins over clear).
  - The read strobe is not driven for status channels.
- Undefined: the live registered-sample behaviour above applies and no clear logic is synthesised.

Decomposition:
- Shared package ghostbus_pkg holds:
  - address-map constants CTRL_BASE='h00 and STAT_BASE='h20;
  - the RLAT_MAX=4 limit;
  - a decode-result enumeration: HIT_CTRL, HIT_STAT, HIT_RAM, HIT_NONE.
- One natural sub-module, ghostbus_rd_pipe:
  - a shift register of RLAT stages carrying {valid, data};
  - stage 0 is loaded from the decode/mux;
  - reset-flushed.

Test Plan:
- Reset with INIT='h42, NCH=4: every ctrl_out lane = 'h42; bus_rvalid=0; then a read of 'h02 returns 'h00000042 exactly RLAT cycles later.
- Write 'h5A to 'h01: ctrl_out[15:8]='h5A on the next cycle, ctrl_wstb=4'b0010 for one cycle only; read of 'h01 → ctrl_rstb=4'b0010 one cycle later, rdata='h5A.
- RLAT=3, reads on four consecutive cycles to 'h40..'h43 after writing RAM 1,2,3,4: rvalid high for four consecutive cycles starting 3 cycles after the first request, data 1,2,3,4 in order.
- Same-cycle write 'h9 and read to RAM 'h41 (holding 2): read returns 2; a subsequent read returns 9.
- Read of unmapped 'h30 and write to 'h20: rdata=0 with rvalid; no strobes; status unchanged.
- Reset asserted one cycle after a read request with RLAT=2: no rvalid appears. With GHOSTBUS_REGBANK_RDCLR_EN: pulse status_in[0] bit 3 for one cycle, read 'h20 → 'h08, read again → 'h00.
